lvds_rx_word_fifo: RTL and testbench
====================================

# lvds_rx_word_fifo

- Buffers 32-bit words produced by the LVDS receive-side word assembler and hands them to the user logic.
- Sits directly downstream of the assembler's `deq_rx` / `EN_deq_rx` / `RDY_deq_rx` handshake and runs entirely in the `rx_outclock` domain.
- Provides RDY/EN handshakes on both sides, occupancy reporting, sticky error flags and an optional frame sequence checker.

## Interface

Parameters:

- `DEPTH`, 16: number of word entries; must be a power of two, minimum 2.
- `AW`, 4: log2(DEPTH).

Ports:

- One clock; reset is asynchronous and active-high.
- `rx_outclock`, in, 1: sole clock; all state updates on its rising edge.
- `pll_areset`, in, 1: asynchronous active-high reset.
- `enq_data`, in, 32: word from the assembler. Bit 31 is the valid marker; bits 30:24 are the sequence number.
- `EN_enq`, in, 1: enqueue strobe; acted on only when `RDY_enq` is high.
- `RDY_enq`, out, 1: high when the FIFO is not full.
- `deq_data`, out, 32: head word, first-word-fall-through.
- `EN_deq`, in, 1: dequeue strobe; acted on only when `RDY_deq` is high.
- `RDY_deq`, out, 1: high when the FIFO is not empty.
- `flush`, in, 1: synchronous clear.
- `count`, out, AW+1: current occupancy, 0..DEPTH.
- `overflow`, out, 1: sticky; set when `EN_enq` is high while `RDY_enq` is low.
- `underflow`, out, 1: sticky; set when `EN_deq` is high while `RDY_deq` is low.
- `seq_err_cnt`, out, 8: saturating count of sequence mismatches.

## Operation

Storage and pointers:

- DEPTH×32 register array, AW-bit read and write pointers, and an AW+1-bit occupancy counter.
- Pointers wrap modulo DEPTH with natural binary rollover.

Enqueue and dequeue:

- An accepted enqueue writes `enq_data` at the write pointer and increments the write pointer.
- An accepted dequeue increments the read pointer.
- `deq_data` always equals the array entry at the read pointer. When the FIFO is empty its value is don't-care, but it must be driven.
- Simultaneous accepted enqueue and dequeue: both pointers advance and `count` is unchanged.
- There is no bypass path:
  - Full: `RDY_enq` is 0, so an enqueue is rejected even if a dequeue happens in the same cycle.
  - Empty: `RDY_deq` is 0, so a dequeue is rejected even if an enqueue happens in the same cycle.
- A rejected strobe sets the matching sticky flag and leaves storage unchanged.

Flush:

- `flush` has priority over enqueue and dequeue in the same cycle.
- It zeroes both pointers and `count`, clears `overflow`, `underflow` and `seq_err_cnt`, and returns the sequence checker to SEED.
- Array contents are not cleared.

Sequence checker (only when compiled in):

- Two states: SEED and TRACK.
- The checker examines only accepted enqueues with `enq_data[31]` = 1. Words with bit 31 = 0 are stored but never checked.
- SEED: on the first checked word, load `exp_seq` = bits[30:24] + 1 (mod 128), then go to TRACK.
- TRACK:
  - If bits[30:24] ≠ `exp_seq`, increment `seq_err_cnt`, saturating at 255.
  - In all cases, resynchronise: `exp_seq` = received value + 1 (mod 128).
- Wrap from 127 to 0 is a correct sequence, not an error.

Reset values:

- `RDY_enq` = 1, `RDY_deq` = 0, `count` = 0.
- `overflow` = 0, `underflow` = 0, `seq_err_cnt` = 0.
- Checker in SEED, both pointers 0.

## Timing

- Enqueue-to-visible latency is 1 cycle: a word accepted at edge N is at the head, with `RDY_deq` = 1, after edge N if the FIFO was empty.
- `RDY_enq`, `RDY_deq` and `count` are registered-state derived (no combinational dependence on `EN_*`). They reflect the state after each edge.
- `deq_data` is a combinational read of the array at the registered read pointer.
- Sticky flags and `seq_err_cnt` update at the same edge as the offending strobe.
- Asserting `pll_areset` mid-operation immediately forces all reset values regardless of clock. Deasserting it resumes operation at the next rising edge.

## Configuration

Macro: `LVDS_RX_FIFO_SEQCHK_EN`.

- Defined: the sequence checker is present as described above.
- Undefined:
  - No checker logic is generated.
  - `seq_err_cnt` is tied to 0.
  - The port list is unchanged.

## Test plan

- Reset then idle:
  - Stimulus: assert `pll_areset`, release, no traffic for 5 cycles.
  - Required: `RDY_enq` = 1, `RDY_deq` = 0, `count` = 0, all flags 0.
- Ordered fill and drain:
  - Stimulus: enqueue 0x8000_0001 … 0x8F00_0010 (16 words, sequence 0..15), then dequeue 16 times.
  - Required: `RDY_enq` = 0 and `count` = 16 after the 16th enqueue; words come out in order; `seq_err_cnt` = 0.
- Full boundary:
  - Stimulus: FIFO full, `EN_enq` = 1 together with `EN_deq` = 1.
  - Required: one word leaves, no word enters, `count` = 15, `overflow` = 1.
- Empty boundary:
  - Stimulus: FIFO empty, `EN_deq` = 1 together with enqueue of 0x8000_00AA.
  - Required: `underflow` = 1; the next cycle `RDY_deq` = 1, `deq_data` = 0x8000_00AA.
- Sequence checker (macro defined):
  - Stimulus: enqueue sequence 126, 127, 0, 5, 6, then a word with bit 31 = 0 and sequence 9.
  - Required: `seq_err_cnt` = 1 at the end; the macro-undefined build gives 0.
- Flush and reset:
  - Stimulus: with 7 words queued and `overflow` = 1, assert `flush` in the same cycle as `EN_enq`.
  - Required: `count` = 0 and all flags 0 the next cycle.
  - Stimulus: repeat, but pulse `pll_areset` between edges.
  - Required: outputs are at reset values before the next edge.

Source files
------------

// File: rtl/lvds_rx_word_fifo_if.sv
// Word handshake, flush and status bundle between the LVDS rx word FIFO and its neighbours.
// slave is the FIFO side; master is the side that drives enqueue/dequeue strobes.
interface lvds_rx_word_fifo_if #(
    parameter int AW = 4
);
    logic [31:0] enq_data;
    logic        EN_enq;
    logic        RDY_enq;
    logic [31:0] deq_data;
    logic        EN_deq;
    logic        RDY_deq;
    logic        flush;
    logic [AW:0] count;
    logic        overflow;
    logic        underflow;
    logic [7:0]  seq_err_cnt;

    modport slave (
        input  enq_data, EN_enq, EN_deq, flush,
        output RDY_enq, deq_data, RDY_deq, count, overflow, underflow, seq_err_cnt
    );

    modport master (
        output enq_data, EN_enq, EN_deq, flush,
        input  RDY_enq, deq_data, RDY_deq, count, overflow, underflow, seq_err_cnt
    );
endinterface

// File: rtl/lvds_rx_word_fifo.sv
// FWFT word FIFO after the LVDS rx assembler; frame sequence checker built only with LVDS_RX_FIFO_SEQCHK_EN.
// Latency: a word enqueued at edge N is at the head after edge N; no enqueue-to-dequeue bypass.
// Backpressure: RDY_enq low when full, RDY_deq low when empty; rejected strobes set sticky flags.
module lvds_rx_word_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 rx_outclock,
    input  logic                 pll_areset,
    lvds_rx_word_fifo_if.slave   f
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          enq_acc;
    logic          deq_acc;

    // Ready flags derive only from registered occupancy, never from the strobes.
    assign f.RDY_enq  = (count_q != FULL_CNT);
    assign f.RDY_deq  = (count_q != '0);
    assign f.count    = count_q;
    assign f.overflow = overflow_q;
    assign f.underflow = underflow_q;
    assign f.deq_data = mem[rd_ptr];

    assign enq_acc = f.EN_enq && f.RDY_enq && !f.flush;
    assign deq_acc = f.EN_deq && f.RDY_deq && !f.flush;

    always_ff @(posedge rx_outclock) begin
        if (enq_acc) begin
            mem[wr_ptr] <= f.enq_data;
        end
    end

    always_ff @(posedge rx_outclock or posedge pll_areset) begin
        if (pll_areset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (f.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (enq_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq_acc, deq_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (f.EN_enq && !f.RDY_enq) begin
                overflow_q <= 1'b1;
            end
            if (f.EN_deq && !f.RDY_deq) begin
                underflow_q <= 1'b1;
            end
        end
    end

`ifdef LVDS_RX_FIFO_SEQCHK_EN
    typedef enum logic {SEED, TRACK} seq_state_t;

    seq_state_t  seq_state;
    logic [6:0]  exp_seq;
    logic [7:0]  seq_err_q;
    logic [6:0]  rx_seq;

    assign rx_seq        = f.enq_data[30:24];
    assign f.seq_err_cnt = seq_err_q;

    // Only stored words carrying the valid marker take part; every checked word resyncs exp_seq.
    always_ff @(posedge rx_outclock or posedge pll_areset) begin
        if (pll_areset) begin
            seq_state <= SEED;
            exp_seq   <= '0;
            seq_err_q <= '0;
        end else if (f.flush) begin
            seq_state <= SEED;
            exp_seq   <= '0;
            seq_err_q <= '0;
        end else if (enq_acc && f.enq_data[31]) begin
            exp_seq <= rx_seq + 7'd1;
            case (seq_state)
                SEED: begin
                    seq_state <= TRACK;
                end
                TRACK: begin
                    if (rx_seq != exp_seq && seq_err_q != 8'hFF) begin
                        seq_err_q <= seq_err_q + 8'd1;
                    end
                end
                default: seq_state <= SEED;
            endcase
        end
    end
`else
    assign f.seq_err_cnt = '0;
`endif
endmodule

// File: tb/tb_lvds_rx_word_fifo.sv
// Directed bench for lvds_rx_word_fifo: reset, fill/drain, full/empty boundaries, sequence checker, flush and async reset.
module tb_lvds_rx_word_fifo;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    lvds_rx_word_fifo_if #(.AW(4)) bus ();

    lvds_rx_word_fifo #(.DEPTH(16), .AW(4)) dut (
        .rx_outclock (clk),
        .pll_areset  (rst),
        .f           (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef LVDS_RX_FIFO_SEQCHK_EN
    localparam logic [31:0] SEQ_EXP = 32'd1;
`else
    localparam logic [31:0] SEQ_EXP = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] d);
        bus.enq_data = d;
        bus.EN_enq   = 1'b1;
        tick();
        bus.EN_enq   = 1'b0;
    endtask

    task automatic deq();
        bus.EN_deq = 1'b1;
        tick();
        bus.EN_deq = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rdy_enq"},   32'(bus.RDY_enq),     32'd1);
        check({tag, "_rdy_deq"},   32'(bus.RDY_deq),     32'd0);
        check({tag, "_count"},     32'(bus.count),       32'd0);
        check({tag, "_overflow"},  32'(bus.overflow),    32'd0);
        check({tag, "_underflow"}, 32'(bus.underflow),   32'd0);
        check({tag, "_seq_err"},   32'(bus.seq_err_cnt), 32'd0);
    endtask

    // Fill with unmarked words, provoke overflow, then drain down to 7 entries.
    task automatic fill_to_seven();
        for (int i = 0; i < 16; i++) enq(32'h0000_0100 + 32'(i));
        enq(32'h0000_0FFF);
        for (int i = 0; i < 9; i++) deq();
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.enq_data = '0;
        bus.EN_enq   = 1'b0;
        bus.EN_deq   = 1'b0;
        bus.flush    = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_idle("reset");

        // Ordered fill: word i carries sequence i with payload i+1.
        for (int i = 0; i < 16; i++) enq(32'h8000_0000 | (32'(i) << 24) | 32'(i + 1));
        check("full_count",   32'(bus.count),       32'd16);
        check("full_rdy_enq", 32'(bus.RDY_enq),     32'd0);
        check("full_seq_err", 32'(bus.seq_err_cnt), 32'd0);
        check("full_head",    bus.deq_data,         32'h8000_0001);

        bus.enq_data = 32'h9000_0099;
        bus.EN_enq   = 1'b1;
        bus.EN_deq   = 1'b1;
        tick();
        bus.EN_enq   = 1'b0;
        bus.EN_deq   = 1'b0;
        check("fullb_count",    32'(bus.count),    32'd15);
        check("fullb_overflow", 32'(bus.overflow), 32'd1);
        check("fullb_rdy_enq",  32'(bus.RDY_enq),  32'd1);

        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_%0d", i), bus.deq_data, 32'h8000_0000 | (32'(i) << 24) | 32'(i + 1));
            deq();
        end
        check("drain_count",     32'(bus.count),     32'd0);
        check("drain_rdy_deq",   32'(bus.RDY_deq),   32'd0);
        check("drain_underflow", 32'(bus.underflow), 32'd0);

        bus.enq_data = 32'h8000_00AA;
        bus.EN_enq   = 1'b1;
        bus.EN_deq   = 1'b1;
        tick();
        bus.EN_enq   = 1'b0;
        bus.EN_deq   = 1'b0;
        check("emptyb_underflow", 32'(bus.underflow), 32'd1);
        check("emptyb_rdy_deq",   32'(bus.RDY_deq),   32'd1);
        check("emptyb_head",      bus.deq_data,       32'h8000_00AA);
        check("emptyb_count",     32'(bus.count),     32'd1);

        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_idle("flush1");

        // Sequence 126,127,0 is a clean wrap; 5 is one mismatch; 6 follows; unmarked 9 is ignored.
        enq(32'hFE00_0001);
        enq(32'hFF00_0002);
        enq(32'h8000_0003);
        check("seq_after_wrap", 32'(bus.seq_err_cnt), 32'd0);
        enq(32'h8500_0004);
        check("seq_after_jump", 32'(bus.seq_err_cnt), SEQ_EXP);
        enq(32'h8600_0005);
        enq(32'h0900_0006);
        check("seq_final",       32'(bus.seq_err_cnt), SEQ_EXP);
        check("seq_count",       32'(bus.count),       32'd6);
        check("seq_head",        bus.deq_data,         32'hFE00_0001);

        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        fill_to_seven();
        check("pre_flush_count",    32'(bus.count),    32'd7);
        check("pre_flush_overflow", 32'(bus.overflow), 32'd1);
        bus.enq_data = 32'h8000_0055;
        bus.EN_enq   = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.EN_enq   = 1'b0;
        bus.flush    = 1'b0;
        check_idle("flush2");

        fill_to_seven();
        check("pre_rst_count",    32'(bus.count),    32'd7);
        check("pre_rst_overflow", 32'(bus.overflow), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        rst = 1'b0;
        tick();
        check_idle("post_rst");
        enq(32'h8000_0077);
        check("post_rst_head",  bus.deq_data,   32'h8000_0077);
        check("post_rst_count", 32'(bus.count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
